// File: rtl/bp_me_pkg.sv
// Shared memory-engine types: fence FSM encoding and credit counter width helper.
`ifndef BP_ME_PKG_SV
`define BP_ME_PKG_SV

// Counter width able to hold 0..credits inclusive.
`define BP_UCE_CREDIT_WIDTH_GP(credits) ($clog2((credits) + 1))

package bp_me_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_drain = 2'd1,
    e_done  = 2'd2
  } bp_uce_fence_state_e;

endpackage

`endif

// File: rtl/bp_uce_resp_fifo.sv
// Small response FIFO with async active-low reset; ready/valid in, valid/yumi out.
module bp_uce_resp_fifo #(
  parameter int unsigned width_p = 600,
  parameter int unsigned els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int unsigned idx_w_lp = $clog2(els_p);
  localparam int unsigned ptr_w_lp = idx_w_lp + 1;

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic                enq, deq, full, empty;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[idx_w_lp-1:0] == rd_ptr_q[idx_w_lp-1:0])
               & (wr_ptr_q[idx_w_lp] != rd_ptr_q[idx_w_lp]);

  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign data_o  = mem_q[rd_ptr_q[idx_w_lp-1:0]];

  assign enq = v_i & ~full;
  assign deq = yumi_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
    if (deq) rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q[idx_w_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_uce_mem_credit_ctrl.sv
// Credit-metered mem_cmd forwarding, buffered mem_resp return and fence drain handshake.
module bp_uce_mem_credit_ctrl
  import bp_me_pkg::*;
#(
  parameter int unsigned mem_msg_width_p = 600,
  parameter int unsigned credits_p       = 8,
  parameter int unsigned resp_els_p      = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [mem_msg_width_p-1:0] mem_cmd_i,
  input  logic                       mem_cmd_v_i,
  output logic                       mem_cmd_ready_o,
  output logic [mem_msg_width_p-1:0] mem_cmd_o,
  output logic                       mem_cmd_v_o,
  input  logic                       mem_cmd_ready_i,
  input  logic [mem_msg_width_p-1:0] mem_resp_i,
  input  logic                       mem_resp_v_i,
  output logic                       mem_resp_ready_o,
  output logic [mem_msg_width_p-1:0] mem_resp_o,
  output logic                       mem_resp_v_o,
  input  logic                       mem_resp_yumi_i,
  input  logic                       fence_i,
  output logic                       fence_done_o,
  output logic                       credits_full_o,
  output logic                       credits_empty_o,
  output logic                       err_o
);

  localparam int unsigned cnt_w_lp = `BP_UCE_CREDIT_WIDTH_GP(credits_p);

  bp_uce_fence_state_e state_q, state_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                err_q, err_d;
  logic                cmd_gate, send, ret, fifo_ready;

  assign credits_full_o  = (count_q == cnt_w_lp'(credits_p));
  assign credits_empty_o = (count_q == '0);
  assign fence_done_o    = (state_q == e_done);
  assign err_o           = err_q;

  // Commands pass straight through only while idle with a free credit and out of reset.
  assign cmd_gate        = reset_n_i & (state_q == e_idle) & ~credits_full_o;
  assign mem_cmd_o       = mem_cmd_i;
  assign mem_cmd_v_o     = mem_cmd_v_i & cmd_gate;
  assign mem_cmd_ready_o = mem_cmd_ready_i & cmd_gate;
  assign send            = mem_cmd_v_o & mem_cmd_ready_i;

  // Credit comes back when the UCE consumes the response, not on network delivery.
  assign ret              = mem_resp_v_o & mem_resp_yumi_i;
  assign mem_resp_ready_o = fifo_ready & reset_n_i;

  bp_uce_resp_fifo #(
    .width_p (mem_msg_width_p),
    .els_p   (resp_els_p)
  ) resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (mem_resp_i),
    .v_i       (mem_resp_v_i),
    .ready_o   (fifo_ready),
    .data_o    (mem_resp_o),
    .v_o       (mem_resp_v_o),
    .yumi_i    (mem_resp_yumi_i)
  );

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    state_d = state_q;

    if (send & ~ret) begin
      count_d = count_q + cnt_w_lp'(1);
    end else if (ret & ~send) begin
      if (count_q == '0) err_d = 1'b1;
      else               count_d = count_q - cnt_w_lp'(1);
    end

    if (mem_resp_yumi_i & ~mem_resp_v_o) err_d = 1'b1;

    unique case (state_q)
      e_idle:  if (fence_i) state_d = e_drain;
      e_drain: if (count_d == '0) state_d = e_done;
      e_done:  state_d = e_idle;
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bp_uce_mem_credit_ctrl.sv
// Directed bench with queue scoreboards for the command and response streams.
module tb_bp_uce_mem_credit_ctrl;

  localparam int unsigned W = 600;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] mem_cmd_i = '0, mem_cmd_o, mem_resp_i = '0, mem_resp_o;
  logic mem_cmd_v_i = 1'b0, mem_cmd_ready_o, mem_cmd_v_o, mem_cmd_ready_i = 1'b1;
  logic mem_resp_v_i = 1'b0, mem_resp_ready_o, mem_resp_v_o, mem_resp_yumi_i = 1'b0;
  logic fence_i = 1'b0, fence_done_o, credits_full_o, credits_empty_o, err_o;

  int checks = 0;
  int failures = 0;
  int nt = 1;
  logic [W-1:0] cmd_q [$];
  logic [W-1:0] resp_q [$];

  bp_uce_mem_credit_ctrl #(
    .mem_msg_width_p (W),
    .credits_p       (8),
    .resp_els_p      (2)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .mem_cmd_i        (mem_cmd_i),
    .mem_cmd_v_i      (mem_cmd_v_i),
    .mem_cmd_ready_o  (mem_cmd_ready_o),
    .mem_cmd_o        (mem_cmd_o),
    .mem_cmd_v_o      (mem_cmd_v_o),
    .mem_cmd_ready_i  (mem_cmd_ready_i),
    .mem_resp_i       (mem_resp_i),
    .mem_resp_v_i     (mem_resp_v_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .mem_resp_o       (mem_resp_o),
    .mem_resp_v_o     (mem_resp_v_o),
    .mem_resp_yumi_i  (mem_resp_yumi_i),
    .fence_i          (fence_i),
    .fence_done_o     (fence_done_o),
    .credits_full_o   (credits_full_o),
    .credits_empty_o  (credits_empty_o),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input int tag);
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = (((tag * 131) + (i * i)) % 3) == 0;
    v[15:0] = 16'(tag);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; expected payloads are queued as they are issued.
  task automatic cyc(input bit cv, input bit rv, input bit y);
    mem_cmd_v_i = cv;
    mem_cmd_i = mk(nt);
    if (cv) cmd_q.push_back(mk(nt));
    nt++;
    mem_resp_v_i = rv;
    mem_resp_i = mk(nt);
    if (rv) resp_q.push_back(mk(nt));
    nt++;
    mem_resp_yumi_i = y;
    tick();
    mem_cmd_v_i = 1'b0;
    mem_resp_v_i = 1'b0;
    mem_resp_yumi_i = 1'b0;
    #1;
  endtask

  task automatic fence_pulse();
    fence_i = 1'b1;
    tick();
    fence_i = 1'b0;
    #1;
  endtask

  // Monitor: pops expected payloads whenever a transfer happens on either stream.
  always @(negedge clk) begin
    if (mem_cmd_v_o && mem_cmd_ready_i) begin
      checks++;
      if (cmd_q.size() == 0) begin
        failures++;
        $display("FAIL cmd_unexpected actual=%0h expected=none", mem_cmd_o[15:0]);
      end else begin
        logic [W-1:0] e;
        e = cmd_q.pop_front();
        if (mem_cmd_o !== e) begin
          failures++;
          $display("FAIL cmd_data actual=%0h expected=%0h", mem_cmd_o[15:0], e[15:0]);
        end
      end
    end
    if (mem_resp_v_o && mem_resp_yumi_i) begin
      checks++;
      if (resp_q.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected actual=%0h expected=none", mem_resp_o[15:0]);
      end else begin
        logic [W-1:0] e;
        e = resp_q.pop_front();
        if (mem_resp_o !== e) begin
          failures++;
          $display("FAIL resp_data actual=%0h expected=%0h", mem_resp_o[15:0], e[15:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with traffic offered.
    mem_cmd_v_i = 1'b1;
    mem_resp_v_i = 1'b1;
    #3;
    chk("rst_cmd_v", 32'(mem_cmd_v_o), 0);
    chk("rst_cmd_ready", 32'(mem_cmd_ready_o), 0);
    chk("rst_resp_ready", 32'(mem_resp_ready_o), 0);
    chk("rst_resp_v", 32'(mem_resp_v_o), 0);
    chk("rst_empty", 32'(credits_empty_o), 1);
    chk("rst_full", 32'(credits_full_o), 0);
    chk("rst_done", 32'(fence_done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    mem_cmd_v_i = 1'b0;
    mem_resp_v_i = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Fill all 8 credits, then the 9th command is blocked.
    for (int i = 0; i < 8; i++) begin
      chk("fill_not_full", 32'(credits_full_o), 0);
      cyc(1, 0, 0);
    end
    chk("fill_full", 32'(credits_full_o), 1);
    chk("fill_count", 32'(dut.count_q), 8);
    mem_cmd_v_i = 1'b1;
    #1;
    chk("fill_9th_ready", 32'(mem_cmd_ready_o), 0);
    chk("fill_9th_v", 32'(mem_cmd_v_o), 0);
    tick();
    mem_cmd_v_i = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0);
      cyc(0, 0, 1);
    end
    chk("drain_empty", 32'(credits_empty_o), 1);

    // Response FIFO backpressure with 3 outstanding commands.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    mem_resp_v_i = 1'b1;
    #1;
    chk("bp_v_latency", 32'(mem_resp_v_o), 0);
    mem_resp_v_i = 1'b0;
    cyc(0, 1, 0);
    chk("bp_v_after", 32'(mem_resp_v_o), 1);
    cyc(0, 1, 0);
    mem_resp_v_i = 1'b1;
    mem_resp_i = mk(999);
    #1;
    chk("bp_3rd_ready", 32'(mem_resp_ready_o), 0);
    tick();
    mem_resp_v_i = 1'b0;
    #1;
    cyc(0, 0, 1);
    chk("bp_ready_freed", 32'(mem_resp_ready_o), 1);
    cyc(0, 0, 1);
    chk("bp_count1", 32'(dut.count_q), 1);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    chk("bp_empty", 32'(credits_empty_o), 1);

    // Concurrent send and return hold the count.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(1, 0, 1);
    chk("conc_hold4", 32'(dut.count_q), 4);
    cyc(0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 1);
      chk("conc_b2b", 32'(dut.count_q), 4);
    end
    cyc(0, 0, 1);
    chk("conc_count3", 32'(dut.count_q), 3);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0);
      cyc(0, 0, 1);
    end
    chk("conc_empty", 32'(credits_empty_o), 1);

    // Fence with 2 outstanding.
    for (int i = 0; i < 2; i++) cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    fence_pulse();
    mem_cmd_v_i = 1'b1;
    #1;
    chk("fence_cmd_v_blk", 32'(mem_cmd_v_o), 0);
    chk("fence_cmd_rdy_blk", 32'(mem_cmd_ready_o), 0);
    chk("fence_done_early", 32'(fence_done_o), 0);
    mem_cmd_v_i = 1'b0;
    cyc(0, 0, 1);
    chk("fence_done_cnt1", 32'(fence_done_o), 0);
    cyc(0, 0, 1);
    chk("fence_done_hi", 32'(fence_done_o), 1);
    chk("fence_cnt0", 32'(credits_empty_o), 1);
    fence_pulse();
    chk("fence_done_1cyc", 32'(fence_done_o), 0);
    tick();
    chk("fence_ignored", 32'(fence_done_o), 0);
    fence_pulse();
    chk("fence0_c1", 32'(fence_done_o), 0);
    tick();
    chk("fence0_c2", 32'(fence_done_o), 1);
    tick();
    chk("fence0_c3", 32'(fence_done_o), 0);
    chk("pre_err", 32'(err_o), 0);

    // Return with count 0.
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    chk("err_ret0", 32'(err_o), 1);
    chk("err_ret0_cnt", 32'(dut.count_q), 0);
    tick();
    tick();
    chk("err_sticky", 32'(err_o), 1);

    // Reset mid-traffic at count 3.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    chk("mid_cnt3", 32'(dut.count_q), 3);
    reset_n = 1'b0;
    mem_cmd_v_i = 1'b1;
    mem_resp_v_i = 1'b1;
    #1;
    chk("mid_cmd_v", 32'(mem_cmd_v_o), 0);
    chk("mid_cmd_ready", 32'(mem_cmd_ready_o), 0);
    chk("mid_resp_ready", 32'(mem_resp_ready_o), 0);
    chk("mid_empty", 32'(credits_empty_o), 1);
    chk("mid_err_clr", 32'(err_o), 0);
    mem_cmd_v_i = 1'b0;
    mem_resp_v_i = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_post_cnt", 32'(dut.count_q), 0);
    chk("mid_post_empty", 32'(credits_empty_o), 1);

    // Yumi while FIFO empty.
    cyc(0, 0, 1);
    chk("err_yumi_empty", 32'(err_o), 1);
    chk("err_yumi_cnt", 32'(dut.count_q), 0);
    tick();
    chk("err_yumi_sticky", 32'(err_o), 1);

    chk("cmd_q_drained", 32'(cmd_q.size()), 0);
    chk("resp_q_drained", 32'(resp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
